// File: rtl/ibex_mem_responder.sv
// ibex_mem_responder: single-outstanding Ibex data bus to word SRAM bridge with read-modify-write for partial stores.
// Define IBEX_MEM_RESP_RANGE_CHECK_EN to return errors for addresses outside the 1 KiB window at BASE_ADDR.
module ibex_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0010_0000,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_cen_o,
  output logic        mem_wen_o,
  output logic [7:0]  mem_addr_o,
  output logic [31:0] mem_data_w_o,
  input  logic [31:0] mem_data_r_i
);
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACCESS, S_CAPTURE, S_WRBACK, S_RESP} state_t;
  state_t state, nxt;
  logic [1:0] cnt;
  logic we_q, err_q;
  logic [3:0] be_q;
  logic [31:0] wd_q, rd_q, wdat_h, merged, off;
  logic [7:0] idx_q, addr_h;
  logic req_err, skip_in, skip, full, unused_off;
  assign off = data_addr_i - BASE_ADDR;
  assign unused_off = ^{off[31:10], off[1:0]};
`ifdef IBEX_MEM_RESP_RANGE_CHECK_EN
  assign req_err = off >= 32'd1024;
`else
  assign req_err = 1'b0;
`endif
  assign skip_in = req_err || (data_we_i && data_be_i == 4'b0000);
  assign skip = err_q || (we_q && be_q == 4'b0000);
  assign full = we_q && be_q == 4'b1111;
  assign data_gnt_o = data_req_i && state == S_IDLE && !rst_i;
  assign data_rvalid_o = state == S_RESP;
  assign data_err_o = state == S_RESP && err_q;
  assign data_rdata_o = (state == S_RESP && !we_q && !err_q) ? rd_q : 32'd0;
  assign mem_cen_o = state == S_ACCESS || state == S_WRBACK;
  assign mem_wen_o = (state == S_ACCESS && full) || state == S_WRBACK;
  assign mem_addr_o = mem_cen_o ? idx_q : addr_h;
  assign mem_data_w_o = state == S_WRBACK ? rd_q : (state == S_ACCESS && full) ? wd_q : wdat_h;
  always_comb begin
    merged = mem_data_r_i;
    for (int i = 0; i < 4; i++) if (be_q[i]) merged[8*i +: 8] = wd_q[8*i +: 8];
  end
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:    nxt = !data_req_i ? S_IDLE : WAIT_CYCLES > 0 ? S_WAIT : skip_in ? S_RESP : S_ACCESS;
      S_WAIT:    nxt = int'(cnt) != WAIT_CYCLES - 1 ? S_WAIT : skip ? S_RESP : S_ACCESS;
      S_ACCESS:  nxt = full ? S_RESP : S_CAPTURE;
      S_CAPTURE: nxt = we_q ? S_WRBACK : S_RESP;
      S_WRBACK:  nxt = S_RESP;
      S_RESP:    nxt = S_IDLE;
      default:   nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= S_IDLE;
      cnt    <= 2'd0;
      we_q   <= 1'b0;
      err_q  <= 1'b0;
      be_q   <= 4'd0;
      wd_q   <= 32'd0;
      idx_q  <= 8'd0;
      rd_q   <= 32'd0;
      addr_h <= 8'd0;
      wdat_h <= 32'd0;
    end else begin
      state <= nxt;
      if (data_gnt_o) begin
        we_q  <= data_we_i;
        be_q  <= data_be_i;
        wd_q  <= data_wdata_i;
        idx_q <= off[9:2];
        err_q <= req_err;
        cnt   <= 2'd0;
      end
      if (state == S_WAIT) cnt <= cnt + 2'd1;
      if (state == S_CAPTURE) rd_q <= we_q ? merged : mem_data_r_i;
      if (mem_cen_o) addr_h <= idx_q;
      if (mem_wen_o) wdat_h <= mem_data_w_o;
    end
  end
endmodule

// File: tb/tb_ibex_mem_responder.sv
// tb_ibex_mem_responder: random and directed transactions checked against a word-array model of the bus semantics.
module tb_ibex_mem_responder;
  localparam logic [31:0] BASE = 32'h0010_0000;
  logic clk = 0, rst = 0;
  always #5 clk = ~clk;
  logic req0 = 0, we0 = 0, gnt0, rv0, err0, cen0, wen0;
  logic [3:0] be0 = 0;
  logic [31:0] a0 = 0, wd0 = 0, rd0, mw0, mr0;
  logic [7:0] ma0;
  logic req3 = 0, we3 = 0, gnt3, rv3, err3, cen3, wen3;
  logic [3:0] be3 = 4'hf;
  logic [31:0] a3 = 0, wd3 = 0, rd3, mw3, mr3;
  logic [7:0] ma3;
  ibex_mem_responder #(.BASE_ADDR(BASE), .WAIT_CYCLES(0)) u0 (
    .clk_i(clk), .rst_i(rst), .data_req_i(req0), .data_gnt_o(gnt0), .data_rvalid_o(rv0),
    .data_we_i(we0), .data_be_i(be0), .data_addr_i(a0), .data_wdata_i(wd0), .data_rdata_o(rd0),
    .data_err_o(err0), .mem_cen_o(cen0), .mem_wen_o(wen0), .mem_addr_o(ma0),
    .mem_data_w_o(mw0), .mem_data_r_i(mr0));
  ibex_mem_responder #(.BASE_ADDR(BASE), .WAIT_CYCLES(3)) u3 (
    .clk_i(clk), .rst_i(rst), .data_req_i(req3), .data_gnt_o(gnt3), .data_rvalid_o(rv3),
    .data_we_i(we3), .data_be_i(be3), .data_addr_i(a3), .data_wdata_i(wd3), .data_rdata_o(rd3),
    .data_err_o(err3), .mem_cen_o(cen3), .mem_wen_o(wen3), .mem_addr_o(ma3),
    .mem_data_w_o(mw3), .mem_data_r_i(mr3));
  logic [31:0] sram0 [256];
  logic [31:0] sram3 [256];
  logic [31:0] ref0 [256];
  always @(posedge clk) if (cen0) begin
    if (wen0) sram0[ma0] <= mw0;
    else mr0 <= sram0[ma0];
  end
  always @(posedge clk) if (cen3) begin
    if (wen3) sram3[ma3] <= mw3;
    else mr3 <= sram3[ma3];
  end
  int n_chk = 0, n_fail = 0;
  logic [7:0] last_addr = 0;
  function automatic logic [31:0] f3(input int i);
    return 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic txn0(input logic we, input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] off, exp_rd, w;
    logic [7:0] idx;
    bit err, skip, full;
    int exp_lat, exp_cen, lat, ncen, nwr;
    off = addr - BASE;
    idx = off[9:2];
`ifdef IBEX_MEM_RESP_RANGE_CHECK_EN
    err = off >= 1024;
`else
    err = 0;
`endif
    skip = err || (we && be == 4'b0000);
    full = we && be == 4'b1111;
    exp_lat = skip ? 1 : full ? 2 : !we ? 3 : 4;
    exp_cen = skip ? 0 : (we && !full) ? 2 : 1;
    exp_rd = (!we && !err) ? ref0[idx] : 32'd0;
    @(negedge clk);
    req0 = 1; we0 = we; be0 = be; a0 = addr; wd0 = wd;
    #1 chk("gnt", 32'(gnt0), 32'd1);
    chk("addr_hold", 32'(ma0), 32'(last_addr));
    ncen = 0; nwr = 0;
    for (lat = 1; lat <= 12; lat++) begin
      @(negedge clk);
      req0 = 0;
      if (cen0) begin
        ncen++;
        chk("mem_addr", 32'(ma0), 32'(idx));
      end
      if (cen0 && wen0) nwr++;
      if (rv0) break;
    end
    chk("latency", lat, exp_lat);
    chk("cen_count", ncen, exp_cen);
    chk("write_count", nwr, (we && !skip) ? 1 : 0);
    chk("rdata", rd0, exp_rd);
    chk("err", 32'(err0), 32'(err));
    if (we && !err) begin
      w = ref0[idx];
      for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
      ref0[idx] = w;
    end
    chk("mem_word", sram0[idx], ref0[idx]);
    if (!skip) last_addr = idx;
  endtask
  initial begin
    int nwr, nrv, first_cen, rv_at, gnt_at, r;
    logic [3:0] be;
    logic [31:0] addr;
    for (int i = 0; i < 256; i++) begin
      sram0[i] = $urandom;
      ref0[i] = sram0[i];
      sram3[i] = f3(i);
    end
    #2 rst = 1;
    req0 = 1;
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {27'd0, gnt0, rv0, err0, cen0, wen0}, 32'd0);
    chk("rst_rdata", rd0, 32'd0);
    chk("rst_maddr", 32'(ma0), 32'd0);
    chk("rst_mdata", mw0, 32'd0);
    req0 = 0;
    rst = 0;
    txn0(1, 4'hf, 32'h0010_0010, 32'hDEADBEEF);
    txn0(0, 4'hf, 32'h0010_0010, 32'd0);
    chk("rd_deadbeef", ref0[4], 32'hDEADBEEF);
    txn0(1, 4'hf, 32'h0010_0020, 32'h1122_3344);
    txn0(1, 4'b0101, 32'h0010_0020, 32'hAABB_CCDD);
    chk("rmw_word", sram0[8], 32'h11BB_33DD);
    txn0(1, 4'b0000, 32'h0010_0030, 32'h1234_5678);
    txn0(0, 4'hf, 32'h0010_0400, 32'd0);
    txn0(0, 4'hf, 32'h000F_FFFC, 32'd0);
    txn0(1, 4'b1000, 32'h0010_03FF, 32'h9900_0000);
    repeat (40) begin
      r = $urandom_range(0, 3);
      be = r == 0 ? 4'h0 : r == 1 ? 4'hf : 4'($urandom);
      addr = $urandom_range(0, 7) == 0 ? $urandom : BASE + ($urandom_range(0, 255) << 2) + $urandom_range(0, 3);
      txn0(1'($urandom), be, addr, $urandom);
    end
    @(negedge clk);
    req0 = 1; we0 = 1; be0 = 4'b0011; a0 = BASE + 32'h40; wd0 = $urandom;
    #1 chk("rst_txn_gnt", 32'(gnt0), 32'd1);
    @(negedge clk);
    req0 = 0;
    chk("rst_txn_access", {30'd0, cen0, wen0}, 32'b10);
    @(negedge clk);
    rst = 1;
    #1 chk("midrst_ctrl", {27'd0, gnt0, rv0, err0, cen0, wen0}, 32'd0);
    chk("midrst_rdata", rd0, 32'd0);
    chk("midrst_maddr", 32'(ma0), 32'd0);
    chk("midrst_mdata", mw0, 32'd0);
    nwr = 0; nrv = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    repeat (6) begin
      @(negedge clk);
      if (cen0 && wen0) nwr++;
      if (rv0) nrv++;
    end
    chk("midrst_writes", nwr, 0);
    chk("midrst_rvalid", nrv, 0);
    chk("midrst_word", sram0[16], ref0[16]);
    last_addr = 0;
    txn0(0, 4'hf, BASE + 32'h40, 32'd0);
    txn0(1, 4'b0110, BASE + 32'h40, 32'hCAFE_F00D);
    @(negedge clk);
    req3 = 1; we3 = 0; a3 = BASE + 32'h0C;
    #1 chk("w3_gnt", 32'(gnt3), 32'd1);
    first_cen = 0; rv_at = 0; gnt_at = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (cen3 && first_cen == 0) first_cen = k;
      if (rv3) begin
        rv_at = k;
        chk("w3_rdata", rd3, f3(3));
      end
      if (gnt3 && gnt_at == 0) gnt_at = k;
    end
    req3 = 0;
    chk("w3_first_cen", first_cen, 4);
    chk("w3_rvalid_at", rv_at, 6);
    chk("w3_regrant_at", gnt_at, 7);
    repeat (10) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
